// File: rtl/uart_rx_frame.sv
// -----------------------------------------------------------------------------
// uart_rx_frame
//
// Asynchronous UART receiver with a configurable frame: 5..9 data bits (LSB
// first), no/odd/even parity and 1 or 2 stop bits. Each bit is decided by a
// 3-sample majority vote. The receiver reports parity, framing and break
// errors alongside each received word.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per bit (8..8191)
//   DATA_BITS     data bits per frame (5..9)
//   PARITY        0 = none, 1 = odd, 2 = even
//   STOP_BITS     stop bits per frame (1 or 2)
//
// Ports
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   input_rx    serial line, idles high, asynchronous to clk
//   out_rx      last received word, held until the next done
//   done        one-cycle strobe when a frame completes
//   parity_err  parity mismatch on the last frame (always 0 when PARITY=0)
//   frame_err   a stop bit was sampled low on the last frame
//   break_det   last frame was entirely low (implies frame_err)
// -----------------------------------------------------------------------------
module uart_rx_frame #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 input_rx,
    output logic [DATA_BITS-1:0] out_rx,
    output logic                 done,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det
);

    localparam int CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int IDX_W  = $clog2(DATA_BITS);
    localparam int HALF_I = (CLKS_PER_BIT - 1) / 2;

    localparam logic [CNT_W-1:0] HALF      = CNT_W'(HALF_I);
    localparam logic [CNT_W-1:0] HALF_M1   = CNT_W'(HALF_I - 1);
    localparam logic [CNT_W-1:0] HALF_M2   = CNT_W'(HALF_I - 2);
    localparam logic [CNT_W-1:0] LAST      = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] LAST_M1   = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [CNT_W-1:0] LAST_M2   = CNT_W'(CLKS_PER_BIT - 3);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                 state;
    state_t                 state_next;

    logic                   sync1;
    logic                   rx_sync;
    logic [CNT_W-1:0]       cnt;
    logic [IDX_W-1:0]       idx;
    logic                   stop_idx;
    logic [DATA_BITS-1:0]   shift;
    logic                   samp_a;
    logic                   samp_b;
    logic                   par_bit;
    logic                   frame_pend;
    logic                   all_low;
    logic                   wait_high;

    logic                   vote;
    logic                   sample_a_hit;
    logic                   sample_b_hit;
    logic                   bit_end;
    logic                   frame_end;
    logic                   par_sum;
    logic                   par_fail;

    // ---- input synchroniser ------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            sync1   <= input_rx;
            rx_sync <= sync1;
        end
    end

    // ---- sample points, vote and parity check -----------------------------
    // The start bit is voted around its middle so that every later bit is
    // voted at the end of a full period, which again lands mid-bit.
    always_comb begin
        vote         = (samp_a & samp_b) | (samp_a & rx_sync) | (samp_b & rx_sync);
        sample_a_hit = 1'b0;
        sample_b_hit = 1'b0;
        bit_end      = 1'b0;
        if (state == S_START) begin
            sample_a_hit = (cnt == HALF_M2);
            sample_b_hit = (cnt == HALF_M1);
            bit_end      = (cnt == HALF);
        end else if (state != S_IDLE) begin
            sample_a_hit = (cnt == LAST_M2);
            sample_b_hit = (cnt == LAST_M1);
            bit_end      = (cnt == LAST);
        end
        frame_end = (state == S_STOP) && bit_end && (stop_idx == STOP_LAST);

        par_sum  = (^shift) ^ par_bit;
        par_fail = 1'b0;
        if (PARITY == 1) begin
            par_fail = ~par_sum;
        end else if (PARITY == 2) begin
            par_fail = par_sum;
        end
    end

    // ---- frame state machine ----------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (!rx_sync && !wait_high) begin
                    state_next = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    // A high vote means the falling edge was only a glitch.
                    state_next = vote ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end && (idx == IDX_LAST)) begin
                    state_next = (PARITY != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_next = S_STOP;
                end
            end
            S_STOP: begin
                // Leaving mid-stop-bit lets the next start edge be caught
                // even with no idle gap between frames.
                if (frame_end) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // ---- bit timing, shift register and result registers ------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            idx        <= '0;
            stop_idx   <= 1'b0;
            shift      <= '0;
            samp_a     <= 1'b1;
            samp_b     <= 1'b1;
            par_bit    <= 1'b0;
            frame_pend <= 1'b0;
            all_low    <= 1'b1;
            wait_high  <= 1'b0;
            out_rx     <= '0;
            done       <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            break_det  <= 1'b0;
        end else begin
            done <= 1'b0;

            if (sample_a_hit) begin
                samp_a <= rx_sync;
            end
            if (sample_b_hit) begin
                samp_b <= rx_sync;
            end

            if (state == S_IDLE) begin
                cnt        <= '0;
                idx        <= '0;
                stop_idx   <= 1'b0;
                frame_pend <= 1'b0;
                all_low    <= 1'b1;
                // A held-low line after a break must go high before re-arming.
                if (wait_high && rx_sync) begin
                    wait_high <= 1'b0;
                end
            end else begin
                cnt <= bit_end ? '0 : cnt + 1'b1;
            end

            if (bit_end && (state != S_START)) begin
                all_low <= all_low & ~vote;
            end

            if ((state == S_DATA) && bit_end) begin
                shift[idx] <= vote;
                idx        <= idx + 1'b1;
            end

            if ((state == S_PARITY) && bit_end) begin
                par_bit <= vote;
            end

            if ((state == S_STOP) && bit_end) begin
                stop_idx <= stop_idx + 1'b1;
                if (!vote) begin
                    frame_pend <= 1'b1;
                end
            end

            if (frame_end) begin
                out_rx     <= shift;
                parity_err <= par_fail;
                frame_err  <= frame_pend | ~vote;
                break_det  <= all_low & ~vote;
                done       <= 1'b1;
                if (all_low && !vote) begin
                    wait_high <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_frame
//
// Bench for uart_rx_frame. Two instances share clock and reset:
//   dut_a  16 clocks/bit, 8 data bits, no parity, 1 stop bit
//   dut_b  16 clocks/bit, 7 data bits, even parity, 2 stop bits
// A serial driver builds each frame and pushes the word/flags it should
// produce; a negedge monitor records every done strobe for the scenario
// tasks to compare.
// -----------------------------------------------------------------------------
module tb_uart_rx_frame;

    localparam int C = 16;

    typedef struct packed {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
        logic       brk;
    } res_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_a  = 1'b1;
    logic       rx_b  = 1'b1;

    logic [7:0] out_a;
    logic       done_a;
    logic       perr_a;
    logic       ferr_a;
    logic       brk_a;

    logic [6:0] out_b;
    logic       done_b;
    logic       perr_b;
    logic       ferr_b;
    logic       brk_b;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   start_cyc = 0;
    int   dbl_a  = 0;
    int   dbl_b  = 0;
    logic prev_a = 1'b0;
    logic prev_b = 1'b0;

    res_t exp_a[$];
    res_t obs_a[$];
    res_t exp_b[$];
    res_t obs_b[$];
    int   cyc_a[$];

    uart_rx_frame #(
        .CLKS_PER_BIT(C),
        .DATA_BITS   (8),
        .PARITY      (0),
        .STOP_BITS   (1)
    ) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .input_rx  (rx_a),
        .out_rx    (out_a),
        .done      (done_a),
        .parity_err(perr_a),
        .frame_err (ferr_a),
        .break_det (brk_a)
    );

    uart_rx_frame #(
        .CLKS_PER_BIT(C),
        .DATA_BITS   (7),
        .PARITY      (2),
        .STOP_BITS   (2)
    ) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .input_rx  (rx_b),
        .out_rx    (out_b),
        .done      (done_b),
        .parity_err(perr_b),
        .frame_err (ferr_b),
        .break_det (brk_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done_a) begin
            obs_a.push_back(res_t'({1'b0, out_a, perr_a, ferr_a, brk_a}));
            cyc_a.push_back(cyc);
        end
        if (done_b) begin
            obs_b.push_back(res_t'({2'b00, out_b, perr_b, ferr_b, brk_b}));
        end
        if (done_a && prev_a) dbl_a <= dbl_a + 1;
        if (done_b && prev_b) dbl_b <= dbl_b + 1;
        prev_a <= done_a;
        prev_b <= done_b;
    end

    task automatic set_line(input int sel, input logic v);
        if (sel == 0) rx_a = v;
        else          rx_b = v;
    endtask

    // One bit period; optional one-cycle inverted glitch at bit offset 7.
    task automatic drive_bit(input int sel, input logic v, input bit glitch);
        set_line(sel, v);
        if (glitch) begin
            repeat (7) @(posedge clk);
            #1 set_line(sel, ~v);
            @(posedge clk);
            #1 set_line(sel, v);
            repeat (C - 8) @(posedge clk);
            #1;
        end else begin
            repeat (C) @(posedge clk);
            #1;
        end
    endtask

    // Drives a whole frame and pushes the result the receiver should report.
    task automatic send_frame(input int sel, input logic [8:0] data, input int nbits,
                              input int par, input int nstop, input bit bad_par,
                              input logic stop_val, input int glitch_pos, input bit align);
        logic [8:0] d;
        logic       p;
        res_t       e;
        int         pos;
        d = data & ((9'h1 << nbits) - 9'h1);
        p = ^d;
        if (par == 1) p = ~p;
        if (bad_par)  p = ~p;
        e.data = d;
        e.perr = (par != 0) && bad_par;
        e.ferr = ~stop_val;
        e.brk  = (d == 9'h0) && !stop_val && ((par == 0) || !p);
        if (sel == 0) exp_a.push_back(e);
        else          exp_b.push_back(e);
        if (align) begin
            @(posedge clk);
            #1;
        end
        start_cyc = cyc;
        pos = 0;
        drive_bit(sel, 1'b0, glitch_pos == pos);
        pos++;
        for (int i = 0; i < nbits; i++) begin
            drive_bit(sel, d[i], glitch_pos == pos);
            pos++;
        end
        if (par != 0) begin
            drive_bit(sel, p, glitch_pos == pos);
            pos++;
        end
        for (int i = 0; i < nstop; i++) begin
            drive_bit(sel, stop_val, glitch_pos == pos);
            pos++;
        end
    endtask

    task automatic wait_obs(input int sel, input int n, input int limit);
        for (int k = 0; k < limit; k++) begin
            if (sel == 0 && obs_a.size() >= n) break;
            if (sel == 1 && obs_b.size() >= n) break;
            @(negedge clk);
        end
    endtask

    task automatic clear_queues;
        exp_a.delete();
        obs_a.delete();
        cyc_a.delete();
        exp_b.delete();
        obs_b.delete();
    endtask

    task automatic test_reset;
        res_t o;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        o = res_t'({1'b0, out_a, perr_a, ferr_a, brk_a});
        checks++;
        if (o !== '0 || done_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_a got out/flags %h done %b want 0 done 0", o, done_a);
        end
        o = res_t'({2'b00, out_b, perr_b, ferr_b, brk_b});
        checks++;
        if (o !== '0 || done_b !== 1'b0) begin
            errors++;
            $display("FAIL reset_b got out/flags %h done %b want 0 done 0", o, done_b);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4 * C) @(negedge clk);
        checks++;
        if (obs_a.size() != 0 || obs_b.size() != 0 || out_a !== 8'h00) begin
            errors++;
            $display("FAIL reset_idle got dones %0d/%0d out %h want 0/0 out 00",
                     obs_a.size(), obs_b.size(), out_a);
        end
        clear_queues();
    endtask

    task automatic test_basic;
        res_t o, e;
        int   lat;
        clear_queues();
        send_frame(0, 9'h0A5, 8, 0, 1, 1'b0, 1'b1, -1, 1'b1);
        wait_obs(0, 1, 4 * C);
        checks++;
        if (obs_a.size() != 1) begin
            errors++;
            $display("FAIL basic_count got %0d dones want 1", obs_a.size());
        end else begin
            o = obs_a.pop_front();
            e = exp_a.pop_front();
            if (o !== e) begin
                errors++;
                $display("FAIL basic_word got %h want %h", o, e);
            end
            // t0 is the edge after the start bit is driven; done is seen
            // in the cycle after edge t0 + 3 + HALF + 9*C.
            lat = cyc_a.pop_front() - start_cyc;
            checks++;
            if (lat != 1 + 3 + 7 + 9 * C) begin
                errors++;
                $display("FAIL basic_latency got %0d want %0d", lat, 1 + 3 + 7 + 9 * C);
            end
        end
    endtask

    task automatic test_parity;
        res_t o, e;
        clear_queues();
        send_frame(1, 9'h041, 7, 2, 2, 1'b1, 1'b1, -1, 1'b1);
        send_frame(1, 9'h041, 7, 2, 2, 1'b0, 1'b1, -1, 1'b1);
        wait_obs(1, 2, 4 * C);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs_b.size() == 0) begin
                errors++;
                $display("FAIL parity_frame%0d got no done want done", i);
            end else begin
                o = obs_b.pop_front();
                e = exp_b.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL parity_frame%0d got %h want %h", i, o, e);
                end
            end
        end
    endtask

    task automatic test_break;
        res_t o, e;
        clear_queues();
        send_frame(0, 9'h03C, 8, 0, 1, 1'b0, 1'b0, -1, 1'b1);
        // The line stays low: the receiver sees one all-zero break frame.
        e = '{data: 9'h000, perr: 1'b0, ferr: 1'b1, brk: 1'b1};
        exp_a.push_back(e);
        set_line(0, 1'b0);
        repeat (20 * C) @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (obs_a.size() != 2) begin
            errors++;
            $display("FAIL break_count got %0d dones want 2", obs_a.size());
        end
        for (int i = 0; i < 2; i++) begin
            if (obs_a.size() != 0) begin
                o = obs_a.pop_front();
                e = exp_a.pop_front();
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL break_frame%0d got %h want %h", i, o, e);
                end
            end
        end
        clear_queues();
        set_line(0, 1'b1);
        repeat (2 * C) @(posedge clk);
        #1;
        checks++;
        if (obs_a.size() != 0) begin
            errors++;
            $display("FAIL break_rearm got %0d dones want 0", obs_a.size());
        end
        clear_queues();
        send_frame(0, 9'h05A, 8, 0, 1, 1'b0, 1'b1, -1, 1'b1);
        wait_obs(0, 1, 4 * C);
        checks++;
        if (obs_a.size() == 0) begin
            errors++;
            $display("FAIL break_after got no done want done");
        end else begin
            o = obs_a.pop_front();
            e = exp_a.pop_front();
            if (o !== e) begin
                errors++;
                $display("FAIL break_after got %h want %h", o, e);
            end
        end
    endtask

    task automatic test_glitch;
        res_t o, e;
        clear_queues();
        @(posedge clk);
        #1 set_line(0, 1'b0);
        @(posedge clk);
        #1 set_line(0, 1'b1);
        repeat (4 * C) @(posedge clk);
        #1;
        checks++;
        if (obs_a.size() != 0) begin
            errors++;
            $display("FAIL glitch_idle got %0d dones want 0", obs_a.size());
        end
        clear_queues();
        // High glitch in the middle of data bit 0 (a zero bit).
        send_frame(0, 9'h052, 8, 0, 1, 1'b0, 1'b1, 1, 1'b1);
        wait_obs(0, 1, 4 * C);
        checks++;
        if (obs_a.size() == 0) begin
            errors++;
            $display("FAIL glitch_data got no done want done");
        end else begin
            o = obs_a.pop_front();
            e = exp_a.pop_front();
            if (o !== e) begin
                errors++;
                $display("FAIL glitch_data got %h want %h", o, e);
            end
        end
    endtask

    task automatic test_back_to_back;
        res_t o, e;
        clear_queues();
        send_frame(0, 9'h000, 8, 0, 1, 1'b0, 1'b1, -1, 1'b1);
        send_frame(0, 9'h0FF, 8, 0, 1, 1'b0, 1'b1, -1, 1'b0);
        send_frame(0, 9'h055, 8, 0, 1, 1'b0, 1'b1, -1, 1'b0);
        wait_obs(0, 3, 4 * C);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs_a.size() == 0) begin
                errors++;
                $display("FAIL b2b_frame%0d got no done want done", i);
            end else begin
                o = obs_a.pop_front();
                e = exp_a.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL b2b_frame%0d got %h want %h", i, o, e);
                end
            end
        end
        checks++;
        if (dbl_a != 0 || dbl_b != 0) begin
            errors++;
            $display("FAIL done_double got %0d/%0d want 0/0", dbl_a, dbl_b);
        end
    endtask

    task automatic test_reset_mid;
        res_t o, e;
        clear_queues();
        @(posedge clk);
        #1;
        drive_bit(0, 1'b0, 1'b0);  // start
        drive_bit(0, 1'b1, 1'b0);  // bit 0 of 0x81
        drive_bit(0, 1'b0, 1'b0);  // bit 1
        set_line(0, 1'b0);         // into bit 2
        repeat (C / 2) @(posedge clk);
        #1 rst_n = 1'b0;
        set_line(0, 1'b1);
        @(negedge clk);
        o = res_t'({1'b0, out_a, perr_a, ferr_a, brk_a});
        checks++;
        if (o !== '0 || done_a !== 1'b0) begin
            errors++;
            $display("FAIL midreset_clear got %h done %b want 0 done 0", o, done_a);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (12 * C) @(negedge clk);
        o = res_t'({1'b0, out_a, perr_a, ferr_a, brk_a});
        checks++;
        if (obs_a.size() != 0 || o !== '0) begin
            errors++;
            $display("FAIL midreset_abort got %0d dones out %h want 0 dones out 0",
                     obs_a.size(), o);
        end
        clear_queues();
        send_frame(0, 9'h081, 8, 0, 1, 1'b0, 1'b1, -1, 1'b1);
        wait_obs(0, 1, 4 * C);
        checks++;
        if (obs_a.size() == 0) begin
            errors++;
            $display("FAIL midreset_next got no done want done");
        end else begin
            o = obs_a.pop_front();
            e = exp_a.pop_front();
            if (o !== e) begin
                errors++;
                $display("FAIL midreset_next got %h want %h", o, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_break();
        test_glitch();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
